// File: rtl/uart_cmd_sender_pkg.sv
// Shared definitions for the badge command sender: command codes, frame lengths,
// FSM state encodings and the frame builder.
package uart_cmd_sender_pkg;

    localparam logic [7:0] CMD_SEND_TX        = 8'h40;
    localparam logic [7:0] CMD_SHOOTING_FLAGS = 8'h41;
    localparam logic [7:0] CMD_AES_KEY        = 8'h42;
    localparam logic [7:0] CMD_AES_PT         = 8'h43;

    localparam int unsigned FRAME_LEN_SHORT = 3;
    localparam int unsigned FRAME_LEN_LONG  = 18;
    localparam int unsigned FRAME_BITS      = 8 * FRAME_LEN_LONG;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {FrIdle, FrSend, FrGap} fr_state_e;

    // Byte k of the frame lives in bits [8k+7:8k]; byte 0 goes out first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic         is_long,
        input logic [7:0]   code,
        input logic [7:0]   arg,
        input logic [127:0] payload
    );
        if (is_long) begin
            return {code, payload, code};
        end
        return {120'd0, code, arg, code};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready input; o_ready rises on the last stop-bit
// cycle so a waiting byte follows with no idle bit in between.
module uart_tx_byte
    import uart_cmd_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10752,
    parameter int unsigned CNT_BITS     = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    output logic       o_tx
);

    tx_state_e           r_state, w_state_next;
    logic [CNT_BITS-1:0] r_cnt, w_cnt_next;
    logic [2:0]          r_bit_idx, w_bit_idx_next;
    logic [7:0]          r_shift, w_shift_next;
    logic                w_wrap;

    assign w_wrap = (r_cnt == CNT_BITS'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TxIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_wrap ? '0 : r_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        o_ready        = 1'b0;
        o_tx           = 1'b1;
        unique case (r_state)
            TxIdle: begin
                o_ready    = 1'b1;
                w_cnt_next = '0;
                if (i_valid) begin
                    w_state_next = TxStart;
                    w_shift_next = i_data;
                end
            end
            TxStart: begin
                o_tx = 1'b0;
                if (w_wrap) begin
                    w_state_next   = TxData;
                    w_bit_idx_next = '0;
                end
            end
            TxData: begin
                o_tx = r_shift[0];
                if (w_wrap) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = TxStop;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            TxStop: begin
                o_ready = w_wrap;
                if (w_wrap) begin
                    if (i_valid) begin
                        w_state_next = TxStart;
                        w_shift_next = i_data;
                    end else begin
                        w_state_next = TxIdle;
                    end
                end
            end
            default: w_state_next = TxIdle;
        endcase
    end

endmodule

// File: rtl/uart_cmd_sender.sv
// Badge command initiator: captures one request, streams its 3- or 18-byte frame as 8N1
// UART and then holds an idle gap. UART_CMD_SENDER_ABORT_EN adds abort/aborted.
module uart_cmd_sender
    import uart_cmd_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10752,
    parameter int unsigned CNT_BITS     = 14,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_long,
    input  logic [7:0]   cmd_code,
    input  logic [7:0]   cmd_arg,
    input  logic [127:0] cmd_payload,
`ifdef UART_CMD_SENDER_ABORT_EN
    input  logic         abort,
    output logic         aborted,
`endif
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    fr_state_e               r_state, w_state_next;
    logic [FRAME_BITS-1:0]   r_frame, w_frame_next;
    logic [4:0]              r_byte_idx, w_byte_idx_next;
    logic [4:0]              r_last_idx, w_last_idx_next;
    logic [GAP_W-1:0]        r_gap_cnt, w_gap_cnt_next;
    logic                    r_done, w_done_next;
    logic                    w_accept, w_more, w_abort_req;
    logic                    w_byte_valid, w_tx_ready;
    logic [7:0]              w_byte_data;

`ifdef UART_CMD_SENDER_ABORT_EN
    logic r_abort_pend, w_abort_pend_next, r_aborted;

    assign w_abort_req = r_abort_pend | abort;
    assign aborted     = r_aborted;

    // Abort is only remembered while bytes are still being sent.
    always_comb begin
        w_abort_pend_next = 1'b0;
        if (r_state == FrSend) begin
            w_abort_pend_next = r_abort_pend | abort;
        end else if (r_state == FrGap) begin
            w_abort_pend_next = r_abort_pend;
        end
    end
`else
    assign w_abort_req = 1'b0;
`endif

    assign cmd_ready    = (r_state == FrIdle) && !reset;
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_more       = (r_byte_idx != r_last_idx) && !w_abort_req;
    // Byte 0 bypasses the frame register so tx drops the cycle after acceptance.
    assign w_byte_valid = w_accept || ((r_state == FrSend) && w_more);
    assign w_byte_data  = (r_state == FrIdle) ? cmd_code : r_frame[15:8];
    assign busy         = (r_state != FrIdle);
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FrIdle;
            r_frame    <= '0;
            r_byte_idx <= '0;
            r_last_idx <= '0;
            r_gap_cnt  <= '0;
            r_done     <= 1'b0;
`ifdef UART_CMD_SENDER_ABORT_EN
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            r_byte_idx <= w_byte_idx_next;
            r_last_idx <= w_last_idx_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_done     <= w_done_next;
`ifdef UART_CMD_SENDER_ABORT_EN
            r_abort_pend <= w_abort_pend_next;
            r_aborted    <= w_done_next && r_abort_pend;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_frame_next    = r_frame;
        w_byte_idx_next = r_byte_idx;
        w_last_idx_next = r_last_idx;
        w_gap_cnt_next  = '0;
        w_done_next     = 1'b0;
        unique case (r_state)
            FrIdle: begin
                if (w_accept) begin
                    w_state_next    = FrSend;
                    w_frame_next    = build_frame(cmd_long, cmd_code, cmd_arg, cmd_payload);
                    w_byte_idx_next = '0;
                    w_last_idx_next = cmd_long ? 5'(FRAME_LEN_LONG - 1)
                                               : 5'(FRAME_LEN_SHORT - 1);
                end
            end
            FrSend: begin
                // Serialiser is ready only on the final stop-bit cycle of the current byte.
                if (w_tx_ready) begin
                    if (w_more) begin
                        w_frame_next    = r_frame >> 8;
                        w_byte_idx_next = r_byte_idx + 5'd1;
                    end else begin
                        w_state_next = FrGap;
                    end
                end
            end
            FrGap: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_next = FrIdle;
                    w_done_next  = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = FrIdle;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_BITS     (CNT_BITS)
    ) u_tx_byte (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_byte_valid),
        .o_ready (w_tx_ready),
        .i_data  (w_byte_data),
        .o_tx    (tx)
    );

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Self-checking bench for uart_cmd_sender: a UART receiver plus a byte-list frame model.
// The abort scenario is compiled only when UART_CMD_SENDER_ABORT_EN is defined.
module tb_uart_cmd_sender;
    import uart_cmd_sender_pkg::*;

    localparam int unsigned CPB      = 4;
    localparam int unsigned GAPB     = 2;
    localparam int unsigned BYTE_CYC = 10 * CPB;
    localparam int unsigned GAP_CYC  = GAPB * CPB;

    logic         clk = 1'b0;
    logic         reset, cmd_valid, cmd_ready, cmd_long, tx, busy, done;
    logic [7:0]   cmd_code, cmd_arg;
    logic [127:0] cmd_payload;
`ifdef UART_CMD_SENDER_ABORT_EN
    logic         abort, aborted;
`endif

    uart_cmd_sender #(
        .CLKS_PER_BIT (CPB),
        .CNT_BITS     (2),
        .GAP_BITS     (GAPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_long    (cmd_long),
        .cmd_code    (cmd_code),
        .cmd_arg     (cmd_arg),
        .cmd_payload (cmd_payload),
`ifdef UART_CMD_SENDER_ABORT_EN
        .abort       (abort),
        .aborted     (aborted),
`endif
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned busy_total = 0, ready_busy_total = 0, done_total = 0, frm_err_total = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_total <= busy_total + 1;
        if (busy === 1'b1 && cmd_ready === 1'b1) ready_busy_total <= ready_busy_total + 1;
        if (done === 1'b1) done_total <= done_total + 1;
    end

    // Receiver: start detected on the first low cycle, bits sampled mid-bit.
    logic [7:0]  rx_q[$];
    int unsigned rx_t[$];
    always begin : uart_mon
        logic [7:0]  d;
        int unsigned t;
        @(negedge clk);
        if (tx === 1'b0) begin
            t = cyc;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) frm_err_total++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) frm_err_total++;
            rx_q.push_back(d);
            rx_t.push_back(t);
        end
    end

    int n_checks = 0, n_errors = 0;
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: code, then arg or the 16 payload bytes low byte first, then code.
    logic [7:0] exp_q[$];
    function automatic void model_frame(input bit lng, input logic [7:0] code,
                                        input logic [7:0] arg, input logic [127:0] pl);
        exp_q.push_back(code);
        if (lng) begin
            for (int k = 0; k < 16; k++) exp_q.push_back(pl[8*k +: 8]);
        end else begin
            exp_q.push_back(arg);
        end
        exp_q.push_back(code);
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned n);
        return n * BYTE_CYC + GAP_CYC;
    endfunction

    task automatic send_req(input bit lng, input logic [7:0] code, input logic [7:0] arg,
                            input logic [127:0] pl, output int unsigned c0);
        @(negedge clk);
        check_eq("ready_before_req", cmd_ready, 1);
        cmd_long = lng; cmd_code = code; cmd_arg = arg; cmd_payload = pl; cmd_valid = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_long    = 1'($urandom);
        cmd_code    = 8'($urandom);
        cmd_arg     = 8'($urandom);
        cmd_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen, output int unsigned dc);
        seen = 1'b0;
        dc   = 0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                dc   = cyc;
            end
        end
    endtask

    task automatic check_bytes(input string tag, input int unsigned base);
        check_eq({tag, "_nbytes"}, rx_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && base + k < rx_q.size(); k++)
            check_eq($sformatf("%s_byte%0d", tag, k), rx_q[base+k], exp_q[k]);
    endtask

    task automatic run_frame(input string tag, input bit lng, input logic [7:0] code,
                             input logic [7:0] arg, input logic [127:0] pl);
        int unsigned n, base, b0, r0, e0, c0, dc, bad;
        bit seen;
        n = lng ? FRAME_LEN_LONG : FRAME_LEN_SHORT;
        exp_q.delete();
        model_frame(lng, code, arg, pl);
        base = rx_q.size(); b0 = busy_total; r0 = ready_busy_total; e0 = frm_err_total;
        send_req(lng, code, arg, pl, c0);
        wait_done(frame_cycles(n) + 20, seen, dc);
        check_eq({tag, "_done_seen"}, seen, 1);
`ifdef UART_CMD_SENDER_ABORT_EN
        check_eq({tag, "_aborted_low"}, aborted, 0);
`endif
        repeat (4) @(negedge clk);
        check_bytes(tag, base);
        if (rx_q.size() > base) begin
            check_eq({tag, "_first_low"}, rx_t[base], c0 + 1);
            check_eq({tag, "_duration"}, dc - rx_t[base], frame_cycles(n));
            bad = 0;
            for (int k = 1; k < n && base + k < rx_q.size(); k++)
                if (rx_t[base+k] - rx_t[base+k-1] != BYTE_CYC) bad++;
            check_eq({tag, "_byte_spacing_bad"}, bad, 0);
        end
        check_eq({tag, "_busy_cycles"}, busy_total - b0, frame_cycles(n));
        check_eq({tag, "_ready_while_busy"}, ready_busy_total - r0, 0);
        check_eq({tag, "_framing_errs"}, frm_err_total - e0, 0);
    endtask

    task automatic run_b2b();
        logic [7:0]  ca, aa, cb, ab;
        int unsigned base, r0, c0, d1, d2;
        bit          s1, s2;
        ca = 8'($urandom); aa = 8'($urandom); cb = 8'($urandom); ab = 8'($urandom);
        exp_q.delete();
        model_frame(0, ca, aa, '0);
        model_frame(0, cb, ab, '0);
        base = rx_q.size(); r0 = ready_busy_total;
        @(negedge clk);
        cmd_long = 1'b0; cmd_code = ca; cmd_arg = aa; cmd_valid = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        cmd_code = cb; cmd_arg = ab;
        wait_done(frame_cycles(3) + 20, s1, d1);
        check_eq("b2b_done1_seen", s1, 1);
        check_eq("b2b_ready_at_done", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(frame_cycles(3) + 20, s2, d2);
        check_eq("b2b_done2_seen", s2, 1);
        // Second frame starts the cycle after done, then runs a full frame.
        check_eq("b2b_done_to_done", d2 - d1, 1 + frame_cycles(3));
        repeat (4) @(negedge clk);
        check_bytes("b2b", base);
        if (rx_q.size() >= base + 4) begin
            check_eq("b2b_first_low", rx_t[base], c0 + 1);
            // Idle between frames: the gap plus the one-cycle accept latency.
            check_eq("b2b_idle_between", rx_t[base+3] - (rx_t[base+2] + BYTE_CYC), GAP_CYC + 1);
        end
        check_eq("b2b_ready_while_busy", ready_busy_total - r0, 0);
    endtask

    task automatic run_reset_mid();
        logic [7:0]   code;
        logic [127:0] pl;
        int unsigned  base, d0, c0, f;
        code = 8'($urandom);
        pl   = {$urandom, $urandom, $urandom, $urandom};
        base = rx_q.size(); d0 = done_total;
        send_req(1, code, 8'h00, pl, c0);
        f = c0 + 1;
        while (cyc < f + BYTE_CYC + 4 * CPB + 1) @(negedge clk);
        check_eq("rst_byte1_bit3", tx, pl[3]);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_tx_high", tx, 1);
        check_eq("rst_busy_low", busy, 0);
        check_eq("rst_ready_low", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_after", cmd_ready, 1);
        repeat (300) @(negedge clk);
        check_eq("rst_no_done", done_total - d0, 0);
        // Receiver sees byte 0 and the truncated byte 1, nothing after the reset.
        check_eq("rst_rx_count", rx_q.size() - base, 2);
        if (rx_q.size() > base) check_eq("rst_byte0", rx_q[base], code);
        run_frame("after_rst", 0, CMD_SEND_TX, 8'($urandom), '0);
    endtask

`ifdef UART_CMD_SENDER_ABORT_EN
    task automatic run_abort();
        logic [7:0]   code;
        logic [127:0] pl;
        int unsigned  base, b0, c0, f, dc;
        bit           seen;
        code = CMD_AES_PT;
        pl   = {$urandom, $urandom, $urandom, $urandom};
        exp_q.delete();
        exp_q.push_back(code); exp_q.push_back(pl[7:0]); exp_q.push_back(pl[15:8]);
        base = rx_q.size(); b0 = busy_total;
        send_req(1, code, 8'h00, pl, c0);
        f = c0 + 1;
        while (cyc < f + 2 * BYTE_CYC + 10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(frame_cycles(FRAME_LEN_LONG) + 20, seen, dc);
        check_eq("abort_done_seen", seen, 1);
        check_eq("abort_aborted_pulse", aborted, 1);
        check_eq("abort_duration", dc - f, frame_cycles(3));
        repeat (4) @(negedge clk);
        check_bytes("abort", base);
        check_eq("abort_busy_cycles", busy_total - b0, frame_cycles(3));
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        run_frame("abort_idle_ignored", 0, CMD_AES_KEY, 8'h5A, '0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pl;
        logic [7:0]   codes[4];
        codes = '{CMD_SEND_TX, CMD_SHOOTING_FLAGS, CMD_AES_KEY, CMD_AES_PT};
        reset = 1'b1; cmd_valid = 1'b0; cmd_long = 1'b0;
        cmd_code = '0; cmd_arg = '0; cmd_payload = '0;
`ifdef UART_CMD_SENDER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_tx", tx, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_ready_in_reset", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_ready_after", cmd_ready, 1);

        run_frame("short", 0, CMD_SHOOTING_FLAGS, 8'h43, '0);
        for (int k = 0; k < 16; k++) pl[8*k +: 8] = 8'(k);
        run_frame("long", 1, CMD_AES_KEY, 8'h00, pl);

        for (int i = 0; i < 5; i++) begin
            logic [7:0] code;
            code = ($urandom_range(0, 1) == 0) ? codes[$urandom_range(0, 3)] : 8'($urandom);
            run_frame($sformatf("rand%0d", i), 1'($urandom), code, 8'($urandom),
                      {$urandom, $urandom, $urandom, $urandom});
        end

        run_b2b();
        run_reset_mid();
`ifdef UART_CMD_SENDER_ABORT_EN
        run_abort();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
